fetch_redirect_ctrl: RTL
========================

# fetch_redirect_ctrl

Pipeline control block on the consumer side of the fetch stage. It captures the fetch stage's `pc`/`inst` into the IF/ID and ID/EX instruction registers and drives the fetch stage's control inputs: `stop`, `pc_sel`, `npc_sel` and `pc_imm`. It resolves JAL in ID, and resolves branches and JALR in EX. It detects load-use hazards and flushes wrong-path instructions.

## Interface
- No parameters.
- `clk_cpu` in 1: core clock; all state updates on the rising edge.
- `rst_cpu` in 1: asynchronous, active-high reset.
- `if_pc` in 32: fetch-stage PC. The fetch stage's reset value is 0xFFFF_FFFC.
- `if_inst` in 32: instruction at `if_pc`.
- `ex_br_taken` in 1: EX branch comparator result. Used only when EX holds a valid branch.
- `stop` out 1: stall fetch; the fetch stage holds its PC.
- `pc_sel` out 1: JALR redirect; the fetch stage loads the ALU result with bit 0 cleared.
- `npc_sel` out 1: immediate redirect; the fetch stage loads `pc_imm`.
- `pc_imm` out 32: immediate redirect target.
- `id_pc`, `id_inst` out 32 each; `id_valid` out 1: IF/ID register.
- `ex_pc`, `ex_inst` out 32 each; `ex_valid` out 1: ID/EX register.
- `redirect_cnt` out 16: saturating count of redirect cycles.

## Operation
- Reset values:
  - `id_pc` and `ex_pc` = 0.
  - `id_inst` and `ex_inst` = 0x0000_0013 (NOP).
  - `id_valid`, `ex_valid` = 0.
  - `redirect_cnt` = 0.
  - With that state, all comb outputs are 0.
- Decode (opcode = `inst[6:0]`):
  - JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011.
  - rs1 is used unless opcode ∈ {0110111, 0010111, 1101111}.
  - rs2 is used iff opcode ∈ {0110011, 0100011, 1100011}.
- Immediates (sign-extended, 32-bit, sums wrap mod 2^32):
  - J-imm = {12×i[31], i[19:12], i[20], i[30:21], 0}.
  - B-imm = {20×i[31], i[7], i[30:25], i[11:8], 0}.
- Redirect sources (combinational from registered state plus `ex_br_taken`; priority high to low):
  1. EX_JALR: `ex_valid` and `ex_inst` is JALR. Drive `pc_sel`=1, `npc_sel`=0, `pc_imm`=0.
  2. EX_BR: `ex_valid`, `ex_inst` is BRANCH, and `ex_br_taken`=1. Drive `npc_sel`=1, `pc_imm` = `ex_pc` + B-imm(`ex_inst`).
  3. ID_JAL: `id_valid` and `id_inst` is JAL. Drive `npc_sel`=1, `pc_imm` = `id_pc` + J-imm(`id_inst`).
  4. LOAD_USE: `ex_valid`, `ex_inst` is LOAD, rd = `ex_inst[11:7]` ≠ 0, `id_valid`, and rd equals a used rs1/rs2 of `id_inst`. Drive `stop`=1.
- If none of these applies, all four control outputs are 0.
- `pc_sel` and `npc_sel` are never both 1. `stop` is never 1 together with a redirect.
- Register update each edge:
  - EX redirect (1 or 2): IF/ID and ID/EX both load a bubble (NOP, valid=0).
  - ID_JAL: IF/ID loads a bubble. ID/EX loads the JAL (valid=1) so its link write proceeds.
  - LOAD_USE: IF/ID holds. ID/EX loads a bubble.
  - Otherwise: ID/EX ← IF/ID. IF/ID ← {`if_pc`, `if_inst`}, with valid = (`if_pc` ≠ 0xFFFF_FFFC). The reset-PC fetch is never valid.
- Bubble `pc` fields: `id_pc`/`ex_pc` are don't-care, but must be deterministic (load 0).
- `redirect_cnt` increments on every edge where `pc_sel` or `npc_sel` is 1, and saturates at 0xFFFF.

## Timing
- Controls are valid in the same cycle as the causing state. The fetch stage applies them at the next edge.
- JAL penalty is 1 bubble; taken branch/JALR penalty is 2 bubbles; load-use stall is 1 cycle.
- An untaken branch causes no action. A branch or JALR with `ex_valid`=0 is ignored.
- EX redirect with a JAL in ID: the EX redirect wins and the JAL is flushed.
- EX redirect with a load-use condition present: the redirect wins and `stop`=0.
- JAL in ID with a load in EX never stalls, because JAL uses no rs.
- Asserting `rst_cpu` mid-operation clears all state immediately, with no edge needed. The first valid `id_pc` after release is 0x0000_0000, two edges after release.

## Test plan
- Reset release with NOPs fetched from pc 0: after edge 1, `id_valid`=0. After edge 2, `id_pc`=0 and `id_valid`=1. All controls stay 0.
- JAL 0x0200006F at pc 0x10: while in ID, `npc_sel`=1 and `pc_imm`=0x30 for exactly 1 cycle. Next cycle `id_valid`=0 and `ex_inst`=0x0200006F. `redirect_cnt`=1.
- BEQ 0x00000863 at pc 0x40, with `ex_br_taken`=1 while in EX: `npc_sel`=1, `pc_imm`=0x50. Next cycle `id_valid`=0 and `ex_valid`=0. Repeat with `ex_br_taken`=0: no redirect and no bubbles.
- LW 0x0000A283 followed by ADD 0x00028333: `stop`=1 for 1 cycle. `id_inst` holds 0x00028333. Next cycle `ex_valid`=0, then the ADD enters EX. Repeat with rd=x0: no stall.
- JALR 0x000080E7 in EX: `pc_sel`=1, `npc_sel`=0, then a 2-bubble flush.
- Taken branch in EX with JAL in ID simultaneously: only `npc_sel`=1 with the branch target. The JAL is flushed and `redirect_cnt` increments by 1. Force 0xFFFF redirects and check that `redirect_cnt` stays at 0xFFFF.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-side pipeline control: holds the IF/ID and ID/EX instruction registers,
// resolves JAL in ID and branches/JALR in EX, and stalls on load-use hazards.
module fetch_redirect_ctrl (
  input  logic        clk_cpu,
  input  logic        rst_cpu,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        ex_br_taken,
  output logic        stop,
  output logic        pc_sel,
  output logic        npc_sel,
  output logic [31:0] pc_imm,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic        ex_valid,
  output logic [15:0] redirect_cnt
);

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_EX_JALR,
    ACT_EX_BR,
    ACT_ID_JAL,
    ACT_LOAD_USE
  } act_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_REG, OP_STORE, OP_BRANCH};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  logic [6:0] id_op;
  logic [6:0] ex_op;
  logic [4:0] ex_rd;
  logic       load_use;
  act_e       act;

  assign id_op = id_inst[6:0];
  assign ex_op = ex_inst[6:0];
  assign ex_rd = ex_inst[11:7];

  // A load whose destination is read by the instruction right behind it.
  assign load_use = ex_valid && (ex_op == OP_LOAD) && (ex_rd != 5'd0) && id_valid &&
                    ((uses_rs1(id_op) && (id_inst[19:15] == ex_rd)) ||
                     (uses_rs2(id_op) && (id_inst[24:20] == ex_rd)));

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    act = ACT_NONE;
    if (ex_valid && (ex_op == OP_JALR))
      act = ACT_EX_JALR;
    else if (ex_valid && (ex_op == OP_BRANCH) && ex_br_taken)
      act = ACT_EX_BR;
    else if (id_valid && (id_op == OP_JAL))
      act = ACT_ID_JAL;
    else if (load_use)
      act = ACT_LOAD_USE;
  end

  always_comb begin
    stop    = 1'b0;
    pc_sel  = 1'b0;
    npc_sel = 1'b0;
    pc_imm  = 32'd0;
    case (act)
      ACT_EX_JALR:  pc_sel = 1'b1;
      ACT_EX_BR: begin
        npc_sel = 1'b1;
        pc_imm  = ex_pc + b_imm(ex_inst);
      end
      ACT_ID_JAL: begin
        npc_sel = 1'b1;
        pc_imm  = id_pc + j_imm(id_inst);
      end
      ACT_LOAD_USE: stop = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      id_pc        <= 32'd0;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      ex_pc        <= 32'd0;
      ex_inst      <= NOP_INST;
      ex_valid     <= 1'b0;
      redirect_cnt <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; ex_* below must see the old id_* contents.
      if ((pc_sel || npc_sel) && (redirect_cnt != 16'hFFFF))
        redirect_cnt <= redirect_cnt + 16'd1;

      case (act)
        ACT_EX_JALR, ACT_EX_BR: begin
          id_pc    <= 32'd0;
          id_inst  <= NOP_INST;
          id_valid <= 1'b0;
          ex_pc    <= 32'd0;
          ex_inst  <= NOP_INST;
          ex_valid <= 1'b0;
        end
        ACT_ID_JAL: begin
          // The JAL itself moves on so its link register write still happens.
          id_pc    <= 32'd0;
          id_inst  <= NOP_INST;
          id_valid <= 1'b0;
          ex_pc    <= id_pc;
          ex_inst  <= id_inst;
          ex_valid <= id_valid;
        end
        ACT_LOAD_USE: begin
          ex_pc    <= 32'd0;
          ex_inst  <= NOP_INST;
          ex_valid <= 1'b0;
        end
        default: begin
          ex_pc    <= id_pc;
          ex_inst  <= id_inst;
          ex_valid <= id_valid;
          id_pc    <= if_pc;
          id_inst  <= if_inst;
          id_valid <= (if_pc != RESET_PC);
        end
      endcase
    end
  end

endmodule
